// File: rtl/node_detector.sv
// rtl/node_detector.sv - debounces three line sensors and emits one pulse per junction
// with hold-off, saturating node count, completion and line-loss flags.
module node_detector #(
  parameter int DEBOUNCE     = 4,
  parameter int HOLDOFF      = 1000,
  parameter int LOST_TIMEOUT = 5000,
  parameter int MAX_NODES    = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sensor_l,
  input  logic       sensor_c,
  input  logic       sensor_r,
  output logic       node_pulse,
  output logic [3:0] node_count,
  output logic       on_line,
  output logic       lost_line,
  output logic       done
);

  localparam int RUN_W  = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(DEBOUNCE);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLDOFF - 1);
  localparam logic [LOST_W-1:0] LOST_LIM = LOST_W'(LOST_TIMEOUT - 1);
  localparam logic [3:0]        MAX_CNT  = 4'(MAX_NODES);

  typedef enum logic [2:0] {
    S_IDLE, S_FOLLOW, S_NODE, S_HOLDOFF, S_LOST, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          raw_q, raw_d;
  logic [2:0]          stable_q, stable_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic [3:0]          count_q, count_d;
  logic                pulse_q, pulse_d;
  logic                on_line_q, on_line_d;
  logic                lost_line_q, lost_line_d;
  logic                done_q, done_d;

  always_comb begin
    raw_d = {sensor_l, sensor_c, sensor_r};
    if (raw_d == raw_q) begin
      run_d = (run_q < RUN_MAX) ? run_q + RUN_W'(1) : run_q;
    end else begin
      run_d = RUN_W'(1);
    end
    // run_q already counts raw_q, so the stable update lands DEBOUNCE+1 cycles after the input moves
    stable_d  = (run_q >= RUN_MAX) ? raw_q : stable_q;
    on_line_d = |stable_q;

    state_d     = state_q;
    count_d     = count_q;
    hold_d      = hold_q;
    lost_cnt_d  = '0;
    pulse_d     = 1'b0;
    lost_line_d = lost_line_q;

    case (state_q)
      S_IDLE: begin
        if (stable_q != 3'b000) state_d = S_FOLLOW;
      end
      S_FOLLOW: begin
        if (stable_q == 3'b111) begin
          state_d = S_NODE;
          pulse_d = 1'b1;
          count_d = (count_q < MAX_CNT) ? count_q + 4'd1 : count_q;
        end else if (stable_q == 3'b000) begin
          if (lost_cnt_q >= LOST_LIM) begin
            state_d     = S_LOST;
            lost_line_d = 1'b1;
          end else begin
            lost_cnt_d = lost_cnt_q + LOST_W'(1);
          end
        end
      end
      S_NODE: begin
        hold_d  = '0;
        state_d = (count_q == MAX_CNT) ? S_DONE : S_HOLDOFF;
      end
      S_HOLDOFF: begin
        // a junction still under the sensors keeps us here, so one crossing gives one pulse
        if (hold_q >= HOLD_LIM && stable_q != 3'b111) begin
          state_d = S_FOLLOW;
        end else if (hold_q < HOLD_LIM) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_LOST:  lost_line_d = 1'b1;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d     = S_IDLE;
      count_d     = '0;
      hold_d      = '0;
      lost_cnt_d  = '0;
      pulse_d     = 1'b0;
      lost_line_d = 1'b0;
    end

    done_d = (count_d == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      raw_q       <= '0;
      stable_q    <= '0;
      run_q       <= '0;
      hold_q      <= '0;
      lost_cnt_q  <= '0;
      count_q     <= '0;
      pulse_q     <= 1'b0;
      on_line_q   <= 1'b0;
      lost_line_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raw_q       <= raw_d;
      stable_q    <= stable_d;
      run_q       <= run_d;
      hold_q      <= hold_d;
      lost_cnt_q  <= lost_cnt_d;
      count_q     <= count_d;
      pulse_q     <= pulse_d;
      on_line_q   <= on_line_d;
      lost_line_q <= lost_line_d;
      done_q      <= done_d;
    end
  end

  assign node_pulse = pulse_q;
  assign node_count = count_q;
  assign on_line    = on_line_q;
  assign lost_line  = lost_line_q;
  assign done       = done_q;

endmodule

// File: tb/tb_node_detector.sv
// tb/tb_node_detector.sv - directed and random stimulus for node_detector against a
// behavioural model built from sample history and cycle timestamps.
module tb_node_detector;

  localparam int DB = 4;
  localparam int HO = 1000;
  localparam int LT = 5000;
  localparam int MN = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sensor_l = 1'b0;
  logic       sensor_c = 1'b0;
  logic       sensor_r = 1'b0;
  logic       node_pulse;
  logic [3:0] node_count;
  logic       on_line;
  logic       lost_line;
  logic       done;

  node_detector #(
    .DEBOUNCE(DB), .HOLDOFF(HO), .LOST_TIMEOUT(LT), .MAX_NODES(MN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sensor_l(sensor_l), .sensor_c(sensor_c), .sensor_r(sensor_r),
    .node_pulse(node_pulse), .node_count(node_count), .on_line(on_line),
    .lost_line(lost_line), .done(done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int pulses = 0;
  int first_pulse = 0;

  // reference model: phases of the crossing, stamped with absolute edge numbers
  localparam int P_WAIT = 0, P_TRACK = 1, P_PULSE = 2, P_GUARD = 3, P_GONE = 4, P_FULL = 5;
  logic [2:0] hist[$];
  logic [2:0] m_stable = 3'b000;
  int phase = P_WAIT;
  int cyc = 0;
  int pulse_cyc = 0;
  int zero_run = 0;
  int e_count = 0;
  bit e_pulse = 0, e_on = 0, e_lost = 0, e_done = 0;

  always @(posedge clk) begin
    logic [2:0] s, prev;
    bit uniform;
    s = {sensor_l, sensor_c, sensor_r};
    if (rst) begin
      hist.delete();
      m_stable = 3'b000;
      phase = P_WAIT;
      zero_run = 0;
      e_count = 0;
      e_pulse = 0; e_on = 0; e_lost = 0; e_done = 0;
    end else begin
      prev = m_stable;
      uniform = (hist.size() >= DB);
      for (int i = 0; i < hist.size(); i++) if (hist[i] != hist[0]) uniform = 0;
      if (uniform) m_stable = hist[hist.size()-1];
      hist.push_back(s);
      if (hist.size() > DB) void'(hist.pop_front());
      e_on = (prev != 3'b000);
      e_pulse = 0;
      if (!enable) begin
        phase = P_WAIT; e_count = 0; e_lost = 0; zero_run = 0;
      end else begin
        case (phase)
          P_WAIT: if (prev != 3'b000) begin phase = P_TRACK; zero_run = 0; end
          P_TRACK: begin
            if (prev == 3'b111) begin
              e_pulse = 1; e_count = (e_count < MN) ? e_count + 1 : e_count;
              phase = P_PULSE; pulse_cyc = cyc;
            end else if (prev == 3'b000) begin
              zero_run++;
              if (zero_run >= LT) begin phase = P_GONE; e_lost = 1; end
            end else zero_run = 0;
          end
          P_PULSE: phase = (e_count == MN) ? P_FULL : P_GUARD;
          P_GUARD: if (cyc - pulse_cyc >= HO + 1 && prev != 3'b111) begin
            phase = P_TRACK; zero_run = 0;
          end
          default: ;
        endcase
      end
      e_done = (e_count == MN);
    end
    cyc++;
  end

  logic [7:0] obs_v, exp_v;
  assign obs_v = {node_pulse, node_count, on_line, lost_line, done};
  assign exp_v = {e_pulse, 4'(e_count), e_on, e_lost, e_done};

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    int bad = 0;
    logic [7:0] bo = '0, be = '0;
    first_pulse = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_v !== exp_v) begin
        if (bad == 0) begin bo = obs_v; be = exp_v; end
        bad++;
      end
      if (node_pulse === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i + 1;
      end
    end
    tests_run++;
    assert (bad == 0) else begin
      tests_failed++;
      $error("FAIL model_track: %0d cycle(s) off, observed %b expected %b", bad, bo, be);
    end
  endtask

  task automatic drive(input logic [2:0] s);
    {sensor_l, sensor_c, sensor_r} = s;
  endtask

  initial begin
    int r;
    // 1: reset then follow a plain line
    rst = 1; run(2);
    chk("reset_outputs", int'(obs_v), 0);
    rst = 0; enable = 1; drive(3'b010); run(10);
    chk("follow_on_line", int'(on_line), 1);
    chk("follow_count", int'(node_count), 0);
    // 2: short junction glitch is filtered
    pulses = 0; drive(3'b111); run(3); drive(3'b010); run(10);
    chk("glitch_pulses", pulses, 0);
    // 3: long junction gives one pulse at cycle 6
    pulses = 0; drive(3'b111); run(2000);
    chk("long_first_pulse", first_pulse, 6);
    chk("long_pulses", pulses, 1);
    drive(3'b010); run(20);
    chk("long_count", int'(node_count), 1);
    // 4: fourteen junctions then an ignored fifteenth
    enable = 0; run(2); enable = 1; run(10);
    pulses = 0;
    for (int k = 0; k < MN; k++) begin
      drive(3'b111); run(20); drive(3'b010); run(1480);
    end
    chk("full_pulses", pulses, MN);
    chk("full_done", int'(done), 1);
    chk("full_count", int'(node_count), MN);
    pulses = 0; drive(3'b111); run(20); drive(3'b010); run(20);
    chk("extra_pulses", pulses, 0);
    chk("extra_count", int'(node_count), MN);
    // 5: line loss is sticky until enable drops
    enable = 0; run(2); enable = 1; run(10);
    pulses = 0; drive(3'b000); run(5003); drive(3'b010); run(20);
    chk("lost_set", int'(lost_line), 1);
    chk("lost_no_pulse", pulses, 0);
    enable = 0; run(1);
    chk("lost_clear", int'(lost_line), 0);
    chk("lost_count", int'(node_count), 0);
    enable = 1; run(10);
    // 6: reset during hold-off with the junction still present
    drive(3'b111); run(100);
    rst = 1; run(1);
    chk("midhold_reset", int'(obs_v), 0);
    rst = 0; pulses = 0; run(20);
    chk("rearm_first_pulse", first_pulse, 7);
    chk("rearm_pulses", pulses, 1);
    // random segments against the model
    for (int k = 0; k < 200; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        rst = 1; run(1); rst = 0;
      end else if (r < 8) begin
        enable = 0; run(int'($urandom_range(1, 3))); enable = 1;
      end
      drive(3'($urandom_range(0, 7)));
      run($urandom_range(0, 1) != 0 ? int'($urandom_range(1, 6)) : int'($urandom_range(7, 400)));
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/node_detector.md
Name: node_detector

Overview:
- Upstream stage of the path controller: converts the three thresholded line sensors into a clean one-cycle node pulse, which drives the path controller's node-advance clock.
- Debounces the raw sensor pattern and recognises a junction as all three sensors on the line.
- Enforces a hold-off between successive nodes, counts nodes and flags completion and line loss.

Parameters:
- DEBOUNCE, 4, consecutive identical raw samples required before the stable pattern updates (≥1).
- HOLDOFF, 1000, minimum clk cycles from a node pulse before another node can be accepted.
- LOST_TIMEOUT, 5000, cycles of stable pattern 000 while following before line loss is declared.
- MAX_NODES, 14, node count at which done asserts (matches the 14-node, 70-bit path).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  1 = detection running; 0 = return to IDLE, counters held
- sensor_l  in  1  left sensor, 1 = black line
- sensor_c  in  1  centre sensor, 1 = black line
- sensor_r  in  1  right sensor, 1 = black line
- node_pulse  out  1  one-cycle pulse per accepted node
- node_count  out  4  nodes accepted since reset/IDLE, saturating at MAX_NODES
- on_line  out  1  stable pattern has at least one sensor set
- lost_line  out  1  sticky line-lost flag
- done  out  1  node_count == MAX_NODES

Behaviour:
- Reset (rst=1 at clk edge) values:
  - node_pulse=0, node_count=0, on_line=0, lost_line=0, done=0.
  - Stable pattern=000; all counters 0; state IDLE.
  - Reset overrides all other inputs in the same cycle, including mid-HOLDOFF.
- Debounce:
  - Raw {l,c,r} is registered once.
  - Run counter increments while the registered raw value equals the previous sample; it resets to 1 on any change.
  - When the run count reaches DEBOUNCE, the stable pattern takes the raw value.
  - Latency from a raw change to a stable change is DEBOUNCE+1 cycles.
  - on_line = OR of the stable pattern, registered.
- FSM states: IDLE, FOLLOW, NODE, HOLDOFF, LOST, DONE.
- IDLE:
  - Outputs cleared except the stable pattern, which keeps updating.
  - Go to FOLLOW when enable=1 and stable != 000.
- FOLLOW:
  - Stable==111 -> NODE.
  - Stable==000 increments the lost counter; reaching LOST_TIMEOUT -> LOST. Any non-000 pattern clears the lost counter.
- NODE (one cycle):
  - node_pulse=1, node_count+1, hold-off counter cleared.
  - If the new count == MAX_NODES -> DONE, else -> HOLDOFF.
- HOLDOFF:
  - Count cycles.
  - Leave for FOLLOW only when the count ≥ HOLDOFF-1 AND stable != 111, so a long junction yields exactly one pulse.
  - Line loss is not checked in HOLDOFF.
- LOST:
  - lost_line=1 (sticky); node_pulse never asserts.
  - Exit only via rst or enable=0 (-> IDLE, lost_line cleared).
- DONE:
  - done=1; node_count held at MAX_NODES; further junctions ignored.
  - Exit via rst or enable=0.
- enable=0 in any state:
  - Next state IDLE; node_count, lost_line and done clear on that edge.
  - A NODE cycle already in progress still completes its pulse.
- Pulse timing and width:
  - node_pulse is registered and exactly one cycle wide.
  - It is high in the cycle after the stable pattern first reads 111 in FOLLOW.
- Width rules: node_count is 4 bits and never exceeds MAX_NODES; counters are sized by $clog2 of their parameter and saturate, with no wrap.
- Simultaneous events: if the stable pattern becomes 111 on the same edge the lost counter would time out, the node wins (111 is not 000).

Test Plan:
1. Reset, enable=1, sensors 010 for 10 cycles -> FOLLOW, on_line=1, node_pulse=0, node_count=0.
2. Sensors 111 held 3 cycles (DEBOUNCE=4) -> no pulse, pattern unchanged.
3. Sensors 111 held 2000 cycles, then 010 -> exactly one node_pulse at cycle 6 after the 111 edge; node_count=1; next junction accepted only after the line returns.
4. Fourteen debounced 111 junctions spaced 1500 cycles apart -> 14 pulses, done=1 after the 14th, a 15th junction gives no pulse and node_count stays 14.
5. Sensors 000 for 5003 cycles in FOLLOW -> lost_line=1 and stays 1 after sensors return to 010; enable=0 then 1 -> lost_line=0, node_count=0.
6. rst asserted mid-HOLDOFF with sensors 111 -> all outputs 0 next cycle; after release, no pulse until 111 is re-debounced from IDLE/FOLLOW.
